// File: rtl/avm_pkg.sv
// Shared types and constants for the UART Avalon-MM read master.
package avm_pkg;

    // Read master FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } avm_state_t;

    // UART slave register map
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    // Receive data register layout: [31:16] words still pending, [15:0] payload
    localparam int RAVAIL_MSB  = 31;
    localparam int RAVAIL_LSB  = 16;
    localparam int RAVAIL_W    = RAVAIL_MSB - RAVAIL_LSB + 1;
    localparam int PAYLOAD_MSB = 15;
    localparam int PAYLOAD_LSB = 0;

endpackage

// File: rtl/uart_avalon_master.sv
// Avalon-MM read master that drains a UART receive data register on irq and
// hands each 16-bit payload to the instruction consumer with a ready strobe.
// All state updates on the falling edge of clock_n_in.
// Optional macro AVM_RAVAIL_BURST_EN: keep reading while the slave reports
// pending words (RAVAIL != 0), regardless of irq_in.
module uart_avalon_master
    import avm_pkg::*;
#(
    parameter logic DATA_ADDR = ADDR_DATA,
    parameter int   INSTR_W   = 16
) (
    input  logic               clock_n_in,
    input  logic               reset_in,
    input  logic [31:0]        readdata_in,
    input  logic               waitrequest_in,
    input  logic               irq_in,
    output logic               chipselect_out,
    output logic               address_out,
    output logic               read_n_out,
    output logic               write_n_out,
    output logic               ready_out,
    output logic [INSTR_W-1:0] instruction_out
);

    avm_state_t         state_reg;
    logic               chipselect_reg;
    logic               address_reg;
    logic               read_n_reg;
    logic               ready_reg;
    logic [INSTR_W-1:0] instruction_reg;
    logic               go_again;

`ifdef AVM_RAVAIL_BURST_EN
    logic [RAVAIL_W-1:0] ravail_reg;

    // Burst mode: pending words in the slave FIFO keep the read loop going
    assign go_again = (ravail_reg != '0) || irq_in;
`else
    logic unused_ravail;

    // Only the interrupt decides whether another read follows
    assign go_again      = irq_in;
    assign unused_ravail = ^readdata_in[RAVAIL_MSB:RAVAIL_LSB];
`endif

    // Single FSM with registered bus and consumer outputs
    always_ff @(negedge clock_n_in) begin
        if (reset_in) begin
            state_reg       <= IDLE;
            chipselect_reg  <= 1'b0;
            address_reg     <= 1'b0;
            read_n_reg      <= 1'b1;
            ready_reg       <= 1'b0;
            instruction_reg <= '0;
`ifdef AVM_RAVAIL_BURST_EN
            ravail_reg      <= '0;
`endif
        end else begin
            address_reg <= DATA_ADDR;
            ready_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    chipselect_reg <= 1'b0;
                    read_n_reg     <= 1'b1;
                    if (irq_in) begin
                        state_reg      <= READ;
                        chipselect_reg <= 1'b1;
                        read_n_reg     <= 1'b0;
                    end
                end
                READ: begin
                    // irq_in is deliberately ignored here: a started read always completes
                    if (!waitrequest_in) begin
                        instruction_reg <= readdata_in[INSTR_W-1:0];
                        ready_reg       <= 1'b1;
`ifdef AVM_RAVAIL_BURST_EN
                        ravail_reg      <= readdata_in[RAVAIL_MSB:RAVAIL_LSB];
`endif
                        state_reg       <= DONE;
                        chipselect_reg  <= 1'b0;
                        read_n_reg      <= 1'b1;
                    end
                end
                DONE: begin
                    // One idle bus cycle between reads
                    if (go_again) begin
                        state_reg      <= READ;
                        chipselect_reg <= 1'b1;
                        read_n_reg     <= 1'b0;
                    end else begin
                        state_reg      <= IDLE;
                        chipselect_reg <= 1'b0;
                        read_n_reg     <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    chipselect_reg <= 1'b0;
                    read_n_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign chipselect_out  = chipselect_reg;
    assign address_out     = address_reg;
    assign read_n_out      = read_n_reg;
    assign write_n_out     = 1'b1;
    assign ready_out       = ready_reg;
    assign instruction_out = instruction_reg;

endmodule

// File: tb/tb_uart_avalon_master.sv
// Self-checking bench for uart_avalon_master: a behavioural UART slave FIFO,
// directed and randomized drain scenarios, and reset-during-stall checks.
// The DUT acts on falling edges; the bench samples and drives on rising edges.

module clock_generator (
    output logic clk
);
    initial clk = 1'b0;
    always #1 clk = ~clk;
endmodule

module tb_uart_avalon_master;

    logic        clk;
    logic        reset_in;
    logic [31:0] readdata_in;
    logic        waitrequest_in;
    logic        irq_in;
    logic        chipselect_out;
    logic        address_out;
    logic        read_n_out;
    logic        write_n_out;
    logic        ready_out;
    logic [15:0] instruction_out;

`ifdef AVM_RAVAIL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    clock_generator u_clk (.clk(clk));

    uart_avalon_master #(.DATA_ADDR(1'b0), .INSTR_W(16)) dut (
        .clock_n_in      (clk),
        .reset_in        (reset_in),
        .readdata_in     (readdata_in),
        .waitrequest_in  (waitrequest_in),
        .irq_in          (irq_in),
        .chipselect_out  (chipselect_out),
        .address_out     (address_out),
        .read_n_out      (read_n_out),
        .write_n_out     (write_n_out),
        .ready_out       (ready_out),
        .instruction_out (instruction_out)
    );

    int          n_assert = 0;
    int          n_fail   = 0;

    // Slave model state
    logic [15:0] fifo[$];
    logic [15:0] captured[$];
    int          popped     = 0;
    int          irq_limit  = 0;
    int          wait_cfg   = 0;
    bit          rand_wait  = 1'b0;
    bit          force_stall = 1'b0;
    bit          in_read    = 1'b0;
    int          wait_left  = 0;

    // Expectations for the next sample
    bit          exp_ready  = 1'b0;
    logic [15:0] exp_instr  = 16'h0;
    logic [15:0] last_instr = 16'h0;
    int          cont_stage = 0;
    bit          exp_cont   = 1'b0;
    bit          irq_rise_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: sample DUT outputs mid-cycle, then drive the slave's response
    task automatic step();
        logic [15:0] payload;
        @(posedge clk);
        check("write_n_high", {31'b0, write_n_out}, 1);
        check("read_n_vs_cs", {31'b0, read_n_out}, {31'b0, ~chipselect_out});
        check("address", {31'b0, address_out}, 0);
        check("ready", {31'b0, ready_out}, {31'b0, exp_ready});
        if (exp_ready) begin
            captured.push_back(instruction_out);
            last_instr = exp_instr;
        end
        check("instr_hold", {16'b0, instruction_out}, {16'b0, last_instr});
        if (cont_stage == 1) begin
            check("done_idle_cycle", {31'b0, chipselect_out}, 0);
            cont_stage = 2;
        end else if (cont_stage == 2) begin
            check("next_read", {31'b0, chipselect_out}, {31'b0, exp_cont});
            cont_stage = 0;
        end
        if (irq_rise_pending) begin
            check("irq_latency", {31'b0, chipselect_out}, 1);
            irq_rise_pending = 1'b0;
        end

        exp_ready = 1'b0;
        if (reset_in || !chipselect_out) begin
            in_read        = 1'b0;
            waitrequest_in = 1'($urandom);
            readdata_in    = $urandom;
        end else begin
            if (!in_read) begin
                in_read   = 1'b1;
                wait_left = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            if (force_stall || wait_left > 0) begin
                waitrequest_in = 1'b1;
                readdata_in    = $urandom;
                if (wait_left > 0) wait_left--;
            end else begin
                if (fifo.size() == 0) begin
                    check("unexpected_read", 1, 0);
                    payload = 16'($urandom);
                end else begin
                    payload = fifo.pop_front();
                end
                popped++;
                readdata_in    = {16'(fifo.size()), payload};
                waitrequest_in = 1'b0;
                exp_ready      = 1'b1;
                exp_instr      = payload;
                irq_in         = (fifo.size() != 0) && (popped < irq_limit);
                exp_cont       = BURST ? ((fifo.size() != 0) || irq_in) : irq_in;
                cont_stage     = 1;
            end
        end
        irq_in = (fifo.size() != 0) && (popped < irq_limit);
    endtask

    // Load the slave FIFO, raise irq, and check the captured word sequence
    task automatic run_scenario(input string name, input logic [15:0] words[$],
                                input int limit, input int wcfg, input bit rw);
        int n_exp;
        int budget;
        n_exp = BURST ? words.size() : ((limit < words.size()) ? limit : words.size());
        captured.delete();
        fifo      = words;
        popped    = 0;
        irq_limit = limit;
        wait_cfg  = wcfg;
        rand_wait = rw;
        irq_in    = (limit > 0) && (words.size() > 0);
        irq_rise_pending = irq_in;
        budget = words.size() * 6 + 12;
        for (int c = 0; c < budget; c++) step();
        check({name, "_count"}, captured.size(), n_exp);
        for (int i = 0; i < n_exp; i++)
            check($sformatf("%s_word%0d", name, i), {16'b0, captured[i]}, {16'b0, words[i]});
        check({name, "_idle"}, {31'b0, chipselect_out}, 0);
        $display("scenario %s: words=%0d irq_limit=%0d captured=%0d", name, words.size(), limit, captured.size());
        fifo.delete();
        irq_limit = 0;
        irq_in    = 1'b0;
    endtask

    initial begin
        logic [15:0] words[$];
        reset_in       = 1'b1;
        irq_in         = 1'b0;
        waitrequest_in = 1'b0;
        readdata_in    = 32'h0;
        @(negedge clk);

        // Reset holds everything at rest while waitrequest toggles
        for (int c = 0; c < 6; c++) begin
            step();
            check("rst_cs", {31'b0, chipselect_out}, 0);
            check("rst_read_n", {31'b0, read_n_out}, 1);
        end
        reset_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("idle_cs", {31'b0, chipselect_out}, 0);
        end

        // Directed drain: irq drops with the last word
        words = '{16'h000A, 16'h0009, 16'h0008, 16'h0007};
        run_scenario("burst4", words, 4, 1, 1'b0);

        // irq drops after the second word
        run_scenario("irqdrop2", words, 2, 1, 1'b0);

        // Zero-wait slave
        words = '{16'h1234, 16'hBEEF, 16'h0000};
        run_scenario("zerowait", words, 3, 0, 1'b0);

        // Randomized scenarios
        for (int s = 0; s < 8; s++) begin
            int n;
            words.delete();
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            run_scenario($sformatf("rand%0d", s), words, int'($urandom_range(1, n)), 0, 1'b1);
        end

        // Reset while a read is stalled
        words = '{16'h5A5A};
        fifo        = words;
        popped      = 0;
        irq_limit   = 1;
        force_stall = 1'b1;
        irq_in      = 1'b1;
        irq_rise_pending = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("stall_cs", {31'b0, chipselect_out}, 1);
        reset_in   = 1'b1;
        fifo.delete();
        irq_limit  = 0;
        last_instr = 16'h0;
        step();
        check("rst_stall_cs", {31'b0, chipselect_out}, 0);
        check("rst_stall_read_n", {31'b0, read_n_out}, 1);
        reset_in    = 1'b0;
        force_stall = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_rst_cs", {31'b0, chipselect_out}, 0);
        end
        $display("scenario reset_stall: done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
